// File: rtl/div_32bit_ctrl_if.sv
// Handshake and operand/result bundle between the MiniMIPS control unit and
// the multi-cycle divider. The control unit is the master side.
interface div_32bit_ctrl_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_32bit_ctrl.sv
// Restoring shift-subtract 32-bit divider for div/divu. It produces one quotient
// bit per cycle, and every subtraction goes through the single sub_32bit instance.
module sub_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        bin_i,
    output logic [31:0] diff_o,
    output logic        bout_o
);
    assign {bout_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {32'd0, bin_i};
endmodule

module div_32bit_ctrl (
    input  logic              clk,
    input  logic              reset,
    div_32bit_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_FIX_Q, S_FIX_R, S_ZERO, S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] r_q, q_q, d_q;
    logic [4:0]  cnt_q;
    logic        d_bin_q, neg_q_q, neg_r_q;
    logic        busy_q, done_q, dbz_q;
    logic [31:0] quotient_q, remainder_q;

    logic [31:0] sub_a, sub_b, sub_diff;
    logic        sub_bin, sub_bout;
    logic [31:0] shift_val, r_step_d, q_step_d;
    logic        step_ge, neg_a, neg_d;

    sub_32bit u_sub (
        .a_i    (sub_a),
        .b_i    (sub_b),
        .bin_i  (sub_bin),
        .diff_o (sub_diff),
        .bout_o (sub_bout)
    );

    // A negative divisor is stored as ~divisor with a borrow-in of 1, so that
    // x - |divisor| = x - ~divisor - 1 needs no separate negation.
    // In IDLE/DONE the subtractor is free, so it forms 0 - dividend for the
    // capture.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sub_a   = '0;
        sub_b   = bus.dividend;
        sub_bin = 1'b0;
        unique case (state_q)
            S_RUN: begin
                sub_a   = shift_val;
                sub_b   = d_q;
                sub_bin = d_bin_q;
            end
            S_FIX_Q: sub_b = q_q;
            S_FIX_R: sub_b = r_q;
            default: ;
        endcase
    end

    assign shift_val = {r_q[30:0], q_q[31]};
    assign step_ge   = r_q[31] | ~sub_bout;
    assign r_step_d  = step_ge ? sub_diff : shift_val;
    assign q_step_d  = {q_q[30:0], step_ge};
    assign neg_a     = bus.is_signed & bus.dividend[31];
    assign neg_d     = bus.is_signed & bus.divisor[31];

    // NOTE: sequential state uses non-blocking assignments only. Reset clears all
    // of it, including the datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            d_bin_q     <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (bus.start) begin
                        r_q     <= '0;
                        cnt_q   <= '0;
                        neg_q_q <= neg_a ^ neg_d;
                        neg_r_q <= neg_a;
                        d_q     <= neg_d ? ~bus.divisor : bus.divisor;
                        d_bin_q <= neg_d;
                        if (bus.divisor == 32'd0) begin
                            q_q     <= bus.dividend;
                            state_q <= S_ZERO;
                        end else begin
                            q_q     <= neg_a ? sub_diff : bus.dividend;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= r_step_d;
                    q_q   <= q_step_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX_Q;
                end
                S_FIX_Q: begin
                    if (neg_q_q) q_q <= sub_diff;
                    state_q <= S_FIX_R;
                end
                S_FIX_R: begin
                    quotient_q  <= q_q;
                    remainder_q <= neg_r_q ? sub_diff : r_q;
                    dbz_q       <= 1'b0;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_DONE;
                end
                S_ZERO: begin
                    quotient_q  <= 32'hFFFF_FFFF;
                    remainder_q <= q_q;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_32bit_ctrl.sv
// Self-checking bench for div_32bit_ctrl: directed cases plus random operands,
// compared against a plain-arithmetic reference model.
module tb_div_32bit_ctrl;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    div_32bit_ctrl_if bus ();

    div_32bit_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } res_t;

    function automatic res_t ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        res_t res;
        res.dbz = 1'b0;
        if (b == 32'd0) begin
            res.q   = 32'hFFFF_FFFF;
            res.r   = a;
            res.dbz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = 32'd0;
        end else if (sg) begin
            res.q = $signed(a) / $signed(b);
            res.r = $signed(a) % $signed(b);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse. With inject_at >= 0,
    // a competing start (5 / 1) is pulsed while the first operation is busy.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input bit back_to_back, input int inject_at, input string tag);
        res_t exp;
        int   lat;
        exp = ref_div(sg, a, b);
        if (!back_to_back) @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        check({tag, " busy_after_start"}, 32'(bus.busy), (b == 0) ? 32'd0 : 32'd1);
        check({tag, " done_low_after_start"}, 32'(bus.done), 32'd0);
        check({tag, " quotient_held"}, bus.quotient, prev_q);
        check({tag, " remainder_held"}, bus.remainder, prev_r);
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == inject_at) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b0;
                bus.dividend  = 32'd5;
                bus.divisor   = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd34);
        check({tag, " quotient"}, bus.quotient, exp.q);
        check({tag, " remainder"}, bus.remainder, exp.r);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp.dbz));
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        prev_q = exp.q;
        prev_r = exp.r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        sg;
        logic [31:0] a, b;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, -1, "u100_7");
        @(negedge clk);
        check("done one cycle", 32'(bus.done), 32'd0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, "s-7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, -1, "s7_-2 b2b");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, -1, "uFFFFFFFF_1");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "s_overflow");
        run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, -1, "u_div0");
        run_op(1'b1, 32'h8765_4321, 32'd0, 1'b1, -1, "s_div0 b2b");
        run_op(1'b1, 32'd10, 32'h8000_0000, 1'b0, -1, "s10_minmag");
        run_op(1'b0, 32'd1000, 32'd10, 1'b0, 10, "start_ignored");

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun reset quotient", bus.quotient, 32'd0);
        check("midrun reset remainder", bus.remainder, 32'd0);
        check("midrun reset busy", 32'(bus.busy), 32'd0);
        check("midrun reset done", 32'(bus.done), 32'd0);
        check("midrun reset dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_q = '0;
        prev_r = '0;
        run_op(1'b0, 32'd9, 32'd3, 1'b0, -1, "after_reset 9_3");

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) b = -32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(sg, a, b, 1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
